// File: rtl/idct_pkg.sv
// Shared constants, widths and output FSM encoding for the 4-point IDCT.
package idct_pkg;

    localparam int IN_W  = 10;
    localparam int SUM_W = 19;
    localparam int OUT_W = 8;
    localparam int SHIFT = 6;

    localparam logic signed [SUM_W-1:0] COEF_A = 32;
    localparam logic signed [SUM_W-1:0] COEF_B = 42;
    localparam logic signed [SUM_W-1:0] COEF_C = 17;
    localparam logic signed [SUM_W-1:0] ROUND  = 32;
    localparam logic signed [SUM_W-1:0] Y_MAX  = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_OUT
    } out_state_e;

    // Round to nearest (ties toward +inf via floor shift), then saturate to 0..255.
    function automatic logic [OUT_W-1:0] round_clamp(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] y;
        y = (s + ROUND) >>> SHIFT;
        if (y[SUM_W-1]) begin
            return '0;
        end else if (y > Y_MAX) begin
            return Y_MAX[OUT_W-1:0];
        end
        return y[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/idct_4pt_core.sv
// Combinational 4-point inverse transform with rounding and clamping.
module idct4_core
    import idct_pkg::*;
(
    input  logic signed [IN_W-1:0]  coef [4],
    output logic        [OUT_W-1:0] samp [4]
);

    logic signed [SUM_W-1:0] x [4];
    logic signed [SUM_W-1:0] s [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            x[k] = SUM_W'(coef[k]);
        end
        s[0] = COEF_A * x[0] + COEF_B * x[1] + COEF_A * x[2] + COEF_C * x[3];
        s[1] = COEF_A * x[0] + COEF_C * x[1] - COEF_A * x[2] - COEF_B * x[3];
        s[2] = COEF_A * x[0] - COEF_C * x[1] - COEF_A * x[2] + COEF_B * x[3];
        s[3] = COEF_A * x[0] - COEF_B * x[1] + COEF_A * x[2] - COEF_C * x[3];
        for (int n = 0; n < 4; n++) begin
            samp[n] = round_clamp(s[n]);
        end
    end

endmodule

// File: rtl/idct_4pt.sv
// Streaming 4-point IDCT: collects X0..X3, transforms, and serialises x0..x3.
module idct_4pt
    import idct_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [IN_W-1:0]        in_data,
    output logic                   out_valid,
    output logic [OUT_W-1:0]       out_data
);

    logic [1:0]              in_cnt_q, in_cnt_d;
    logic signed [IN_W-1:0]  coef_q [4];
    logic signed [IN_W-1:0]  coef_d [4];
    logic [OUT_W-1:0]        buf_q [4];
    logic [OUT_W-1:0]        buf_d [4];
    logic [OUT_W-1:0]        core_y [4];
    out_state_e              state_q, state_d;
    logic [1:0]              out_cnt_q, out_cnt_d;
    logic                    pend_q, pend_d;
    logic                    out_valid_q, out_valid_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic                    blk_done;

    idct4_core u_core (
        .coef (coef_q),
        .samp (core_y)
    );

    assign blk_done  = in_valid && (in_cnt_q == 2'd3);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        in_cnt_d = in_cnt_q;
        coef_d   = coef_q;
        if (in_valid) begin
            coef_d[in_cnt_q] = in_data;
            in_cnt_d         = in_cnt_q + 2'd1;
        end
    end

    // A block finishing while samples stream out is held in pend_q and loaded
    // on the last output cycle, so the buffer never changes under a live block.
    always_comb begin
        state_d     = state_q;
        out_cnt_d   = out_cnt_q;
        pend_d      = pend_q;
        buf_d       = buf_q;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (blk_done) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                buf_d     = core_y;
                state_d   = ST_OUT;
                out_cnt_d = 2'd0;
                pend_d    = blk_done;
            end
            ST_OUT: begin
                out_valid_d = 1'b1;
                out_data_d  = buf_q[out_cnt_q];
                out_cnt_d   = out_cnt_q + 2'd1;
                if (out_cnt_q == 2'd3) begin
                    if (pend_q) begin
                        buf_d  = core_y;
                        pend_d = 1'b0;
                    end else if (blk_done) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (blk_done) begin
                    pend_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt_q    <= '0;
            state_q     <= ST_IDLE;
            out_cnt_q   <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < 4; k++) begin
                coef_q[k] <= '0;
                buf_q[k]  <= '0;
            end
        end else begin
            in_cnt_q    <= in_cnt_d;
            coef_q      <= coef_d;
            state_q     <= state_d;
            out_cnt_q   <= out_cnt_d;
            pend_q      <= pend_d;
            buf_q       <= buf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_idct_4pt.sv
// Bench for idct_4pt: table vectors, corner sequences and randomized blocks
// checked against an arithmetic model with cycle-exact output timing.
module tb_idct_4pt;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [9:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;

    int checks;
    int failures;
    int cyc;

    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];

    typedef struct {
        int x[4];
        int y[4];
    } vec_t;

    vec_t tbl[6];
    int   xv[4];
    int   yv[4];

    idct_4pt dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    task automatic model(input int x[4], output int y[4]);
        int m[4][4];
        int s;
        int v;
        int q;
        m = '{'{32, 42, 32, 17}, '{32, 17, -32, -42},
              '{32, -17, -32, 42}, '{32, -42, 32, -17}};
        for (int n = 0; n < 4; n++) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += m[n][k] * x[k];
            v = s + 32;
            q = (v >= 0) ? v / 64 : -((-v + 63) / 64);
            if (q < 0) q = 0;
            if (q > 255) q = 255;
            y[n] = q;
        end
    endtask

    function automatic int rand_coef();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 1023)) - 512;
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_cycle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 10'($urandom);
    endtask

    task automatic send_coef(input int v, output int t);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 10'(v);
        t        = cyc + 1;
    endtask

    // mode 0: contiguous, 1: random gaps, 2: three idle cycles after X0
    task automatic send_block(input int x[4], input int y[4], input int mode);
        int t;
        int g;
        t = 0;
        for (int k = 0; k < 4; k++) begin
            g = 0;
            if (mode == 1) g = int'($urandom_range(0, 3));
            if (mode == 2 && k == 1) g = 3;
            repeat (g) idle_cycle();
            send_coef(x[k], t);
        end
        for (int n = 0; n < 4; n++) begin
            exp_q.push_back(8'(y[n]));
            exp_cyc_q.push_back(t + 2 + n);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0) begin
            failures++;
            $display("FAIL async_reset got valid=%0b data=%0d want valid=0 data=0",
                     out_valid, out_data);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                    failures++;
                    $display("FAIL sample cyc=%0d got valid=%0b data=%0d want valid=1 data=%0d",
                             cyc, out_valid, out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end else begin
                checks++;
                if (out_valid !== 1'b0 || out_data !== 8'd0) begin
                    failures++;
                    $display("FAIL idle cyc=%0d got valid=%0b data=%0d want valid=0 data=0",
                             cyc, out_valid, out_data);
                end
            end
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        failures++;
        $display("FAIL watchdog got cycles=%0d want completion before limit", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- test sequence ----------------
    initial begin
        int t;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        tbl[0] = '{x: '{64, 0, 0, 0},    y: '{32, 32, 32, 32}};
        tbl[1] = '{x: '{0, 64, 0, 0},    y: '{42, 17, 0, 0}};
        tbl[2] = '{x: '{511, 0, 0, 0},   y: '{255, 255, 255, 255}};
        tbl[3] = '{x: '{-512, 0, 0, 0},  y: '{0, 0, 0, 0}};
        tbl[4] = '{x: '{128, 0, 64, 0},  y: '{96, 32, 32, 96}};
        tbl[5] = '{x: '{0, 0, 0, 0},     y: '{0, 0, 0, 0}};

        #3;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0) begin
            failures++;
            $display("FAIL reset_state got valid=%0b data=%0d want valid=0 data=0",
                     out_valid, out_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) idle_cycle();

        // table vectors, isolated blocks
        for (int i = 0; i < 6; i++) begin
            send_block(tbl[i].x, tbl[i].y, 0);
            repeat (8) idle_cycle();
        end

        // back-to-back: three blocks on 12 consecutive coefficients
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 4; k++) xv[k] = rand_coef();
            model(xv, yv);
            send_block(xv, yv, 0);
        end
        repeat (10) idle_cycle();

        // gapped block
        send_block(tbl[0].x, tbl[0].y, 2);
        repeat (8) idle_cycle();

        // reset after X1 of a partial block
        send_coef(rand_coef(), t);
        send_coef(rand_coef(), t);
        do_reset();
        send_block(tbl[0].x, tbl[0].y, 0);
        repeat (8) idle_cycle();

        // reset while a block is streaming out
        for (int k = 0; k < 4; k++) xv[k] = rand_coef();
        model(xv, yv);
        send_block(xv, yv, 0);
        idle_cycle();
        repeat (3) @(posedge clk);
        do_reset();
        send_block(tbl[0].x, tbl[0].y, 0);
        repeat (8) idle_cycle();

        // randomized blocks with random gaps
        for (int b = 0; b < 40; b++) begin
            for (int k = 0; k < 4; k++) xv[k] = rand_coef();
            model(xv, yv);
            send_block(xv, yv, 1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) idle_cycle();
        end
        repeat (12) idle_cycle();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idct_4pt.md
IDCT_4PT -- requirements
Module: idct_4pt

Interface
REQ-001 One clock; reset is asynchronous and active-high.
REQ-002 Ports (name  direction  width  meaning):
  clk        input   1   system clock, all state on rising edge
  rst        input   1   asynchronous active-high reset
  in_valid   input   1   in_data carries one coefficient this cycle
  in_data    input   10  signed two's-complement coefficient X[k], k = 0..3 in order
  out_valid  output  1   out_data carries one reconstructed sample this cycle
  out_data   output  8   unsigned sample x[n], n = 0..3 in order
REQ-003 Parameters: none; all constants come from the shared package.

Function
REQ-004 Block is 4 coefficients X0..X3; each in_valid cycle captures one coefficient; an input counter (0..3) advances only on in_valid, so gaps inside a block are legal.
REQ-005 Capture of X3 (counter = 3) completes the block; the counter wraps to 0 in the same cycle.
REQ-006 Transform, sums signed 19-bit:
  s0 = 32X0 + 42X1 + 32X2 + 17X3
  s1 = 32X0 + 17X1 - 32X2 - 42X3
  s2 = 32X0 - 17X1 - 32X2 + 42X3
  s3 = 32X0 - 42X1 + 32X2 - 17X3
REQ-007 Rounding: y = (s + 32) arithmetic-shifted right by 6 (floor); clamp y < 0 -> 0 and y > 255 -> 255.
REQ-008 Latency: X3 captured at edge t -> the 4 clamped results are registered into the output buffer at edge t+1 -> x0..x3 are driven at edges t+2..t+5 with out_valid high on exactly those 4 cycles.
REQ-009 Input and output registers are separate, so the next block may be accepted during output; block-to-block throughput is 1 coefficient/cycle with no stall.
REQ-010 If a new block completes while the previous block is still streaming out, the input controller shall not modify the output buffer before the last sample of the previous block is driven; with 1 coefficient/cycle this never conflicts, and the output controller does not reload until its counter returns to 0.
REQ-011 Output FSM: IDLE (out_valid = 0) -> LOAD on block completion -> OUT for 4 cycles (counter 0..3) -> IDLE, or -> OUT at sample 0 directly if a load is pending on the last OUT cycle.
REQ-012 out_data = 0 whenever out_valid = 0.
REQ-013 in_valid is ignored in no state; there is no backpressure and no ready signal.

Reset
REQ-014 rst asserted: out_valid = 0, out_data = 0, input counter = 0, FSM = IDLE, coefficient and output registers = 0, all immediately (asynchronous).
REQ-015 rst mid-block or mid-output discards the partial block and remaining samples; the first in_valid after release is X0 of a new block.

Structure
REQ-016 Package idct_pkg holds: coefficient constants (32, 42, 17), shift 6, round offset 32, widths (IN_W 10, SUM_W 19, OUT_W 8), and the output FSM state enum.
REQ-017 Sub-module idct4_core: purely combinational; 4 coefficients in, 4 clamped 8-bit samples out (REQ-006, REQ-007); the top holds all state.

Verification
REQ-018 DC: X = (64,0,0,0) -> outputs 32,32,32,32, out_valid high exactly cycles t+2..t+5.
REQ-019 AC/clamp low: X = (0,64,0,0) -> 42,17,0,0.
REQ-020 Saturation: X = (511,0,0,0) -> 255,255,255,255; X = (-512,0,0,0) -> 0,0,0,0.
REQ-021 Back-to-back: 3 blocks on 12 consecutive in_valid cycles -> 12 consecutive out_valid cycles, each block's samples correct, no gaps.
REQ-022 Gapped input: X0, idle 3 cycles, X1..X3 -> same results as the contiguous block; latency counted from X3.
REQ-023 Reset: assert rst after X1 of block A and again during its output -> out_valid falls at once; the next 4 inputs (64,0,0,0) produce 32,32,32,32.
